mem_tx_arbiter: RTL

- N-channel successor to the two-source (scheduler/prefetcher) TX arbitration and reply-tracking logic in front of memory_interface.
- Arbitrates TX ownership among NUM_CH requesters, holds ownership for a whole transaction, and tracks outstanding reply-bearing reads in an internal FIFO.
- Routes RX strobes to the channel that issued each read.
- Adds configurable channel count, outstanding depth, round-robin mode and a sticky protocol-error flag.

---
 rtl/mem_tx_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_tx_arbiter.sv
// TX ownership arbiter for N channels in front of memory_interface.
// Tracks reply-bearing reads and steers RX strobes to the issuing channel.
module mem_tx_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IO_BITS = 2,
  parameter int CMD_BITS = 2,
  parameter logic [CMD_BITS-1:0] READ_CMD = CMD_BITS'(1),
  parameter int MAX_OUTSTANDING = 3,
  parameter int RR_MODE = 0,
  parameter int DEFAULT_CH = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [NUM_CH-1:0] req_reserve,
  input  logic [NUM_CH*CMD_BITS-1:0] req_cmd,
  input  logic [NUM_CH*IO_BITS-1:0] req_data,
  input  logic [NUM_CH-1:0] req_reply_wanted,
  output logic mi_tx_command_valid,
  output logic [CMD_BITS-1:0] mi_tx_command,
  output logic [IO_BITS-1:0] mi_tx_data,
  input  logic mi_tx_command_started,
  input  logic mi_tx_active,
  input  logic mi_tx_data_next,
  input  logic mi_tx_done,
  input  logic mi_rx_started,
  input  logic mi_rx_active,
  input  logic mi_rx_sbs_valid,
  input  logic mi_rx_data_valid,
  input  logic mi_rx_done,
  output logic [NUM_CH-1:0] tx_owner,
  output logic [NUM_CH-1:0] rx_owner,
  output logic [NUM_CH-1:0] ch_tx_command_started,
  output logic [NUM_CH-1:0] ch_tx_active,
  output logic [NUM_CH-1:0] ch_tx_data_next,
  output logic [NUM_CH-1:0] ch_tx_done,
  output logic [NUM_CH-1:0] ch_rx_started,
  output logic [NUM_CH-1:0] ch_rx_active,
  output logic [NUM_CH-1:0] ch_rx_sbs_valid,
  output logic [NUM_CH-1:0] ch_rx_data_valid,
  output logic [NUM_CH-1:0] ch_rx_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic full,
  output logic protocol_error
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int PTR_W =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam idx_t DEF_IDX = idx_t'(DEFAULT_CH);
  localparam idx_t LAST_IDX = idx_t'(NUM_CH-1);
  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(MAX_OUTSTANDING);
  localparam ptr_t LAST_PTR = ptr_t'(MAX_OUTSTANDING-1);
  localparam logic [NUM_CH-1:0] ONE =
    {{(NUM_CH-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0] cand;
  idx_t win;
  idx_t owner;
  idx_t owner_q;
  idx_t rr_ptr;
  logic found;
  int j;

  logic is_read;
  logic empty;
  logic push_req;
  logic pop_req;
  logic push;
  logic pop;

  idx_t fifo_idx [MAX_OUTSTANDING];
  logic fifo_rw [MAX_OUTSTANDING];
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic [CNT_W-1:0] count;

  assign cand = req_valid | req_reserve;

  // RR searches upward from the slot after the last started owner
  always_comb begin
    win = DEF_IDX;
    found = 1'b0;
    j = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= NUM_CH) j = j - NUM_CH;
        if (!found && cand[idx_t'(j)]) begin
          win = idx_t'(j);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cand[idx_t'(i)]) win = idx_t'(i);
      end
    end
  end

  assign owner = mi_tx_active ? owner_q : win;
  assign tx_owner = ONE << owner;

  assign mi_tx_command =
    req_cmd[owner*CMD_BITS +: CMD_BITS];
  assign mi_tx_data =
    req_data[owner*IO_BITS +: IO_BITS];

  assign is_read = (mi_tx_command == READ_CMD);
  assign mi_tx_command_valid =
    req_valid[owner] & ~(full & is_read);

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= DEF_IDX;
      rr_ptr <= LAST_IDX;
    end else begin
      if (!mi_tx_active) owner_q <= win;
      if (mi_tx_command_started) rr_ptr <= owner;
    end
  end

  assign empty = (count == '0);
  assign full = (count == MAX_CNT);
  assign outstanding = count;

  assign push_req = mi_tx_command_started & is_read;
  assign pop_req = mi_rx_done;
  assign push = push_req & ~full;
  assign pop = pop_req & ~empty;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= owner;
      fifo_rw[wr_ptr] <= req_reply_wanted[owner];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      unique case ({push, pop})
        2'b10: count <= count + CNT_W'(1);
        2'b01: count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // overflow push and underflow pop are dropped but remembered
      if ((push_req & full) | (pop_req & empty))
        protocol_error <= 1'b1;
    end
  end

  assign rx_owner =
    (!empty && fifo_rw[rd_ptr]) ?
    (ONE << fifo_idx[rd_ptr]) : '0;

  assign ch_tx_command_started =
    {NUM_CH{mi_tx_command_started}} & tx_owner;
  assign ch_tx_active =
    {NUM_CH{mi_tx_active}} & tx_owner;
  assign ch_tx_data_next =
    {NUM_CH{mi_tx_data_next}} & tx_owner;
  assign ch_tx_done =
    {NUM_CH{mi_tx_done}} & tx_owner;

  assign ch_rx_started =
    {NUM_CH{mi_rx_started}} & rx_owner;
  assign ch_rx_active =
    {NUM_CH{mi_rx_active}} & rx_owner;
  assign ch_rx_sbs_valid =
    {NUM_CH{mi_rx_sbs_valid}} & rx_owner;
  assign ch_rx_data_valid =
    {NUM_CH{mi_rx_data_valid}} & rx_owner;
  assign ch_rx_done =
    {NUM_CH{mi_rx_done}} & rx_owner;

endmodule
